// File: rtl/ariane_pkg.sv
// Shared front-end types: fetch entry handed from IF to ID and the fetch queue depth.
package ariane_pkg;

    localparam int unsigned VLEN              = 64;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        cf_t             cf;
        logic [VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [VLEN-1:0]    address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue_pkg.sv
// Local helpers for the instruction queue: encoding of the per-cycle queue operation.
package instr_queue_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/instr_queue_if.sv
// IF -> queue -> ID handshake bundle; master is the IF/ID side, slave is the queue.
interface instr_queue_if
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush;
    fetch_entry_t       in_entry;
    logic               in_valid;
    logic               in_ready;
    fetch_entry_t       fetch_entry;
    logic               fetch_entry_valid;
    logic               fetch_ack;
    logic [CNT_W-1:0]   count;

    modport master (
        output flush, in_entry, in_valid, fetch_ack,
        input  in_ready, fetch_entry, fetch_entry_valid, count
    );

    modport slave (
        input  flush, in_entry, in_valid, fetch_ack,
        output in_ready, fetch_entry, fetch_entry_valid, count
    );

endinterface

// File: rtl/instr_queue.sv
// Circular-buffer fetch queue between IF and ID; one-cycle latency, no bypass,
// ready derived only from registered occupancy.
module instr_queue
    import ariane_pkg::*;
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  fetch_entry_t              in_entry_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output fetch_entry_t              fetch_entry_o,
    output logic                      fetch_entry_valid_o,
    input  logic                      fetch_ack_i,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [DEPTH];

    logic  push_c, pop_c;
    q_op_e op_c;

    // Ready looks only at stored occupancy, so a same-cycle pop never frees a slot.
    assign in_ready_o          = (count_q < CNT_W'(DEPTH));
    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_o       = mem_q[rd_ptr_q];
    assign count_o             = count_q;

    assign push_c = in_valid_i & in_ready_o & ~flush_i;
    assign pop_c  = fetch_ack_i & fetch_entry_valid_o & ~flush_i;
    assign op_c   = q_op_e'({push_c, pop_c});

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case (op_c)
                OP_PUSH: count_q <= count_q + CNT_W'(1);
                OP_POP:  count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the occupancy decides what is live.
    always_ff @(posedge clk_i) begin
        if (push_c && !rst_i) mem_q[wr_ptr_q] <= in_entry_i;
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        push_c |-> (count_q < CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        pop_c |-> (count_q != '0));

endmodule
